// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with modulus, wrap-or-saturate bounds,
// synchronous clear/load and registered terminal-count and wrap pulses.
module param_up_down_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned STEP      = 1,
  parameter longint unsigned MODULUS   = 256,
  parameter int unsigned     SATURATE  = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MOD_X   = W1'(MODULUS);
  localparam logic [WIDTH:0] MAX_X   = W1'(MODULUS - 1);
  localparam logic [WIDTH:0] STEP_X  = W1'(STEP);
  localparam logic [WIDTH:0] RESET_X = W1'(RESET_VAL);

  if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) ||
      STEP < 1 || STEP >= MODULUS || RESET_VAL >= MODULUS || SATURATE > 1) begin : g_param_check
    $error("param_up_down_counter: illegal parameter combination");
  end

  // Count is held one bit wider than the port so sums never overflow.
  logic [WIDTH:0] count_q, count_d;
  logic           tc_q, tc_d;
  logic           wrap_q, wrap_d;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] load_x;

  assign load_x = {1'b0, load_val};

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    wrap_d  = 1'b0;
    sum_x   = count_q + STEP_X;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_x < MOD_X) ? load_x : MAX_X;
    end else if (en) begin
      if (up) begin
        if (sum_x <= MAX_X) begin
          count_d = sum_x;
        end else begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? MAX_X : (sum_x - MOD_X);
        end
        tc_d = (count_d == MAX_X);
      end else begin
        if (count_q >= STEP_X) begin
          count_d = count_q - STEP_X;
        end else begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? '0 : (count_q + MOD_X - STEP_X);
        end
        tc_d = (count_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RESET_X;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q[WIDTH-1:0];
  assign tc    = tc_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: four parameter sets share one
// stimulus stream, each scenario task checks the instance it targets.
module tb_param_up_down_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, clear, load;
  logic [7:0] lv;

  logic [7:0] cnt_a, cnt_d;
  logic [3:0] cnt_b, cnt_c;
  logic       tc_a, wr_a, tc_b, wr_b, tc_c, wr_c, tc_d, wr_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_up_down_counter u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .count(cnt_a), .tc(tc_a), .wrap(wr_a));

  param_up_down_counter #(.WIDTH(4), .STEP(3), .MODULUS(10)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .count(cnt_b), .tc(tc_b), .wrap(wr_b));

  param_up_down_counter #(.WIDTH(4), .STEP(4), .MODULUS(10), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[3:0]), .count(cnt_c), .tc(tc_c), .wrap(wr_c));

  param_up_down_counter #(.WIDTH(8), .STEP(5), .MODULUS(200), .RESET_VAL(7)) u_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .count(cnt_d), .tc(tc_d), .wrap(wr_d));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lv = 8'd0;
    step(); step();
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
    total++; if (cnt_d !== 8'd7) begin bad++; $display("FAIL reset_cnt_d got=%0d exp=7", cnt_d); end
    total++; if ({tc_a, wr_a, tc_d, wr_d} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {tc_a, wr_a, tc_d, wr_d}); end
    rst = 1'b1;
    step();
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_release_idle got=%0d exp=0", cnt_a); end
  endtask

  task automatic test_wrap_default();
    int exp_c = 0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step();
      exp_c = (exp_c + 1) % 256;
      total++; if (cnt_a !== 8'(exp_c)) begin bad++; $display("FAIL def_up_cnt i=%0d got=%0d exp=%0d", i, cnt_a, exp_c); end
      total++; if (tc_a !== (exp_c == 255)) begin bad++; $display("FAIL def_up_tc i=%0d got=%b exp=%b", i, tc_a, exp_c == 255); end
      total++; if (wr_a !== (exp_c == 0)) begin bad++; $display("FAIL def_up_wrap i=%0d got=%b exp=%b", i, wr_a, exp_c == 0); end
    end
    en = 1'b0;
  endtask

  task automatic test_mod10_wrap();
    int up_c[7]  = '{3, 6, 9, 2, 5, 8, 1};
    int up_w[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int up_t[7]  = '{0, 0, 1, 0, 0, 0, 0};
    int dn_c[4]  = '{8, 5, 2, 9};
    int dn_w[4]  = '{1, 0, 0, 1};
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (cnt_b !== 4'd0) begin bad++; $display("FAIL m10_clear got=%0d exp=0", cnt_b); end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      total++; if ({cnt_b, wr_b, tc_b} !== {4'(up_c[i]), 1'(up_w[i]), 1'(up_t[i])})
        begin bad++; $display("FAIL m10_up i=%0d got cnt=%0d w=%b t=%b exp cnt=%0d w=%0d t=%0d", i, cnt_b, wr_b, tc_b, up_c[i], up_w[i], up_t[i]); end
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({cnt_b, wr_b, tc_b} !== {4'(dn_c[i]), 1'(dn_w[i]), 1'b0})
        begin bad++; $display("FAIL m10_down i=%0d got cnt=%0d w=%b t=%b exp cnt=%0d w=%0d t=0", i, cnt_b, wr_b, tc_b, dn_c[i], dn_w[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    int up_c[4] = '{4, 8, 9, 9};
    int dn_c[4] = '{5, 1, 0, 0};
    int fl[4]   = '{0, 0, 1, 1};
    clear = 1'b1; step(); clear = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({cnt_c, wr_c, tc_c} !== {4'(up_c[i]), 1'(fl[i]), 1'(fl[i])})
        begin bad++; $display("FAIL sat_up i=%0d got cnt=%0d w=%b t=%b exp cnt=%0d w=t=%0d", i, cnt_c, wr_c, tc_c, up_c[i], fl[i]); end
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({cnt_c, wr_c, tc_c} !== {4'(dn_c[i]), 1'(fl[i]), 1'(fl[i])})
        begin bad++; $display("FAIL sat_down i=%0d got cnt=%0d w=%b t=%b exp cnt=%0d w=t=%0d", i, cnt_c, wr_c, tc_c, dn_c[i], fl[i]); end
    end
    en = 1'b0;
    step();
    total++; if ({cnt_c, wr_c, tc_c} !== {4'd0, 2'b00}) begin bad++; $display("FAIL sat_idle got cnt=%0d w=%b t=%b exp 0 0 0", cnt_c, wr_c, tc_c); end
  endtask

  task automatic test_priority();
    load = 1'b1; lv = 8'd5; step();
    total++; if (cnt_a !== 8'd5) begin bad++; $display("FAIL pri_load5 got=%0d exp=5", cnt_a); end
    clear = 1'b1; load = 1'b1; lv = 8'd7; en = 1'b1; up = 1'b1; step();
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd0, 2'b00}) begin bad++; $display("FAIL pri_clear_wins got=%0d exp=0", cnt_a); end
    clear = 1'b0; step();
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd7, 2'b00}) begin bad++; $display("FAIL pri_load_over_en got=%0d exp=7", cnt_a); end
    lv = 8'd200; step();
    total++; if (cnt_d !== 8'd199) begin bad++; $display("FAIL clamp_200 got=%0d exp=199", cnt_d); end
    lv = 8'd250; step();
    total++; if (cnt_d !== 8'd199) begin bad++; $display("FAIL clamp_250 got=%0d exp=199", cnt_d); end
    lv = 8'd255; step();
    total++; if (cnt_a !== 8'd255) begin bad++; $display("FAIL load_max got=%0d exp=255", cnt_a); end
    lv = 8'd199; step(); load = 1'b0;
    step();
    total++; if ({cnt_d, wr_d, tc_d} !== {8'd4, 2'b10}) begin bad++; $display("FAIL m200_up_wrap got cnt=%0d w=%b t=%b exp 4 1 0", cnt_d, wr_d, tc_d); end
    up = 1'b0; step();
    total++; if ({cnt_d, wr_d, tc_d} !== {8'd199, 2'b10}) begin bad++; $display("FAIL m200_down_wrap got cnt=%0d w=%b t=%b exp 199 1 0", cnt_d, wr_d, tc_d); end
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_async_reset();
    load = 1'b1; lv = 8'd40; step(); load = 1'b0;
    en = 1'b1; up = 1'b1; step(); step();
    total++; if (cnt_a !== 8'd42) begin bad++; $display("FAIL ar_pre got=%0d exp=42", cnt_a); end
    #2 rst = 1'b0;
    #1;
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd0, 2'b00}) begin bad++; $display("FAIL ar_immediate got=%0d exp=0", cnt_a); end
    total++; if (cnt_d !== 8'd7) begin bad++; $display("FAIL ar_immediate_d got=%0d exp=7", cnt_d); end
    step(); step();
    total++; if ({cnt_a, cnt_d} !== {8'd0, 8'd7}) begin bad++; $display("FAIL ar_held got a=%0d d=%0d exp 0 7", cnt_a, cnt_d); end
    rst = 1'b1; step();
    total++; if ({cnt_a, cnt_d} !== {8'd1, 8'd12}) begin bad++; $display("FAIL ar_resume got a=%0d d=%0d exp 1 12", cnt_a, cnt_d); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    load = 1'b1; lv = 8'd16; step(); load = 1'b0;
    en = 1'b1; step(); en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if ({cnt_a, tc_a, wr_a} !== {8'd17, 2'b00}) begin bad++; $display("FAIL hold i=%0d got cnt=%0d t=%b w=%b exp 17 0 0", i, cnt_a, tc_a, wr_a); end
    end
    en = 1'b1; step();
    total++; if (cnt_a !== 8'd18) begin bad++; $display("FAIL hold_resume got=%0d exp=18", cnt_a); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; up = 1'b0; step();
    total++; if (cnt_a !== 8'd17) begin bad++; $display("FAIL dir_down got=%0d exp=17", cnt_a); end
    up = 1'b1; step();
    total++; if (cnt_a !== 8'd18) begin bad++; $display("FAIL dir_up got=%0d exp=18", cnt_a); end
    load = 1'b1; lv = 8'd1; step(); load = 1'b0;
    up = 1'b0; step();
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd0, 2'b10}) begin bad++; $display("FAIL down_to0 got cnt=%0d t=%b w=%b exp 0 1 0", cnt_a, tc_a, wr_a); end
    step();
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd255, 2'b01}) begin bad++; $display("FAIL down_wrap got cnt=%0d t=%b w=%b exp 255 0 1", cnt_a, tc_a, wr_a); end
    up = 1'b1; step();
    total++; if ({cnt_a, tc_a, wr_a} !== {8'd0, 2'b01}) begin bad++; $display("FAIL up_wrap got cnt=%0d t=%b w=%b exp 0 0 1", cnt_a, tc_a, wr_a); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_default();
    test_mod10_wrap();
    test_saturate();
    test_priority();
    test_async_reset();
    test_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
